// File: rtl/synch_ctrl.sv
// RX synchroniser sequencer: coarse plateau detection, fine peak search, data alignment and output gating.
// Optional statistics counters (Det_Cnt, Fail_Cnt, Frm_Cnt) are built when SYNCH_CTRL_STAT_EN is defined.
module synch_ctrl #(
  parameter int PLAT_LEN = 32,
  parameter int MIN_PWR  = 64,
  parameter int FINE_WIN = 144,
  parameter int CR_THR   = 40,
  parameter int LTS_OFS  = 192,
  parameter int SYM_LEN  = 80
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        Smp_Val,
  input  logic        CM_Val,
  input  logic [22:0] P_Mag,
  input  logic [21:0] R_Metric,
  input  logic        CR_Val,
  input  logic [7:0]  CR_Mag,
  input  logic [9:0]  Frm_Nsym,
  output logic        Fine_En,
  output logic        Out_En,
  output logic        Frm_Start,
  output logic [9:0]  Sym_Cnt,
  output logic [7:0]  Peak_Idx,
  output logic        Synch_Fail,
  output logic [2:0]  State
`ifdef SYNCH_CTRL_STAT_EN
  ,
  output logic [15:0] Det_Cnt,
  output logic [15:0] Fail_Cnt,
  output logic [15:0] Frm_Cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COARSE = 3'd1,
    FINE   = 3'd2,
    ALIGN  = 3'd3,
    DATA   = 3'd4
  } state_t;

  localparam logic [21:0] L_MIN_PWR   = 22'(MIN_PWR);
  localparam logic [7:0]  L_PLAT_LAST = 8'(PLAT_LEN - 1);
  localparam logic [7:0]  L_WIN_LAST  = 8'(FINE_WIN - 1);
  localparam logic [7:0]  L_CR_THR    = 8'(CR_THR);
  localparam logic [8:0]  L_W_OFS     = 9'(LTS_OFS - FINE_WIN);
  localparam logic [7:0]  L_SYM_LAST  = 8'(SYM_LEN - 1);

  state_t      r_state;
  logic [7:0]  r_plat;
  logic [7:0]  r_win_cnt;
  logic [7:0]  r_max;
  logic [7:0]  r_peak_idx;
  logic        r_win_done;
  logic [8:0]  r_w;
  logic        r_fine_en;
  logic        r_out_en;
  logic        r_fail;
  logic        r_first;
  logic [9:0]  r_nsym;
  logic [9:0]  r_sym_cnt;
  logic [7:0]  r_samp_cnt;

  logic [21:0] w_r_thr;
  logic        w_hit;
  logic        w_abort;
  logic        w_detect;
  logic        w_decide;
  logic        w_low_peak;
  logic        w_fail_set;
  logic [8:0]  w_w;
  logic        w_enter_data;
  logic        w_frm_start;
  logic        w_wrap;
  logic [9:0]  w_sym_next;

  // Hit threshold is 3/4 of the energy metric.
  assign w_r_thr      = R_Metric - (R_Metric >> 2);
  assign w_hit        = CM_Val && (R_Metric >= L_MIN_PWR) && (P_Mag >= {1'b0, w_r_thr});
  assign w_abort      = (r_state != IDLE) && !CYC_I;
  assign w_detect     = (r_state == COARSE) && !w_abort && w_hit && (r_plat == L_PLAT_LAST);
  assign w_decide     = (r_state == FINE) && r_win_done && !w_abort;
  assign w_low_peak   = (r_max < L_CR_THR);
  assign w_fail_set   = (w_abort && ((r_state == FINE) || (r_state == ALIGN))) ||
                        (w_decide && w_low_peak);
  assign w_w          = {1'b0, r_peak_idx} + L_W_OFS;
  assign w_enter_data = (w_decide && !w_low_peak && (w_w == 9'd0)) ||
                        ((r_state == ALIGN) && !w_abort && Smp_Val && (r_w == 9'd1));
  assign w_frm_start  = (r_state == DATA) && r_first && Smp_Val && CYC_I;
  assign w_wrap       = (r_state == DATA) && Smp_Val && CYC_I && (r_samp_cnt == L_SYM_LAST);
  assign w_sym_next   = (r_sym_cnt == 10'h3FF) ? r_sym_cnt : r_sym_cnt + 10'd1;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state    <= IDLE;
      r_plat     <= '0;
      r_win_cnt  <= '0;
      r_max      <= '0;
      r_peak_idx <= '0;
      r_win_done <= 1'b0;
      r_w        <= '0;
      r_fine_en  <= 1'b0;
      r_out_en   <= 1'b0;
      r_fail     <= 1'b0;
      r_first    <= 1'b0;
      r_nsym     <= '0;
      r_sym_cnt  <= '0;
      r_samp_cnt <= '0;
    end else begin
      r_fail <= w_fail_set;
      case (r_state)
        IDLE: begin
          r_plat <= '0;
          if (CYC_I) r_state <= COARSE;
        end
        COARSE: begin
          if (w_detect) begin
            r_state    <= FINE;
            r_fine_en  <= 1'b1;
            r_win_cnt  <= '0;
            r_max      <= '0;
            r_win_done <= 1'b0;
            r_plat     <= '0;
          end else if (CM_Val) begin
            r_plat <= w_hit ? r_plat + 8'd1 : 8'd0;
          end
        end
        FINE: begin
          if (w_decide) begin
            if (w_low_peak) begin
              r_state <= COARSE;
              r_plat  <= '0;
            end else begin
              r_w     <= w_w;
              r_state <= ALIGN;
            end
          end else if (CR_Val && !r_win_done) begin
            // Strict compare keeps the earliest of equal peaks.
            if (CR_Mag > r_max) begin
              r_max      <= CR_Mag;
              r_peak_idx <= r_win_cnt;
            end
            r_win_cnt <= r_win_cnt + 8'd1;
            if (r_win_cnt == L_WIN_LAST) begin
              r_fine_en  <= 1'b0;
              r_win_done <= 1'b1;
            end
          end
        end
        ALIGN: begin
          if (Smp_Val) r_w <= r_w - 9'd1;
        end
        DATA: begin
          if (w_frm_start) r_first <= 1'b0;
          if (Smp_Val && CYC_I) begin
            if (w_wrap) begin
              r_samp_cnt <= '0;
              r_sym_cnt  <= w_sym_next;
              if ((r_nsym != 10'd0) && (w_sym_next == r_nsym)) begin
                r_out_en <= 1'b0;
                r_state  <= IDLE;
              end
            end else begin
              r_samp_cnt <= r_samp_cnt + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_enter_data) begin
        r_state    <= DATA;
        r_out_en   <= 1'b1;
        r_nsym     <= Frm_Nsym;
        r_sym_cnt  <= '0;
        r_samp_cnt <= '0;
        r_first    <= 1'b1;
      end
      // Abort wins over every other transition.
      if (w_abort) begin
        r_state   <= IDLE;
        r_fine_en <= 1'b0;
        r_out_en  <= 1'b0;
      end
    end
  end

  assign Fine_En    = r_fine_en;
  assign Out_En     = r_out_en;
  assign Frm_Start  = w_frm_start;
  assign Sym_Cnt    = r_sym_cnt;
  assign Peak_Idx   = r_peak_idx;
  assign Synch_Fail = r_fail;
  assign State      = r_state;

`ifdef SYNCH_CTRL_STAT_EN
  logic [15:0] r_det_cnt;
  logic [15:0] r_fail_cnt;
  logic [15:0] r_frm_cnt;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_det_cnt  <= '0;
      r_fail_cnt <= '0;
      r_frm_cnt  <= '0;
    end else begin
      if (w_detect && (r_det_cnt != 16'hFFFF))     r_det_cnt  <= r_det_cnt + 16'd1;
      if (w_fail_set && (r_fail_cnt != 16'hFFFF))  r_fail_cnt <= r_fail_cnt + 16'd1;
      if (w_frm_start && (r_frm_cnt != 16'hFFFF))  r_frm_cnt  <= r_frm_cnt + 16'd1;
    end
  end

  assign Det_Cnt  = r_det_cnt;
  assign Fail_Cnt = r_fail_cnt;
  assign Frm_Cnt  = r_frm_cnt;
`endif

endmodule

// File: tb/tb_synch_ctrl.sv
// Directed self-checking bench for synch_ctrl with default parameters.
module tb_synch_ctrl;
  logic        CLK_I = 1'b0;
  logic        RST_I, CYC_I, Smp_Val, CM_Val, CR_Val;
  logic [22:0] P_Mag;
  logic [21:0] R_Metric;
  logic [7:0]  CR_Mag;
  logic [9:0]  Frm_Nsym;
  logic        Fine_En, Out_En, Frm_Start, Synch_Fail;
  logic [9:0]  Sym_Cnt;
  logic [7:0]  Peak_Idx;
  logic [2:0]  State;
`ifdef SYNCH_CTRL_STAT_EN
  logic [15:0] Det_Cnt, Fail_Cnt, Frm_Cnt;
`endif

  int checks = 0;
  int errors = 0;

  synch_ctrl dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .Smp_Val(Smp_Val),
    .CM_Val(CM_Val), .P_Mag(P_Mag), .R_Metric(R_Metric),
    .CR_Val(CR_Val), .CR_Mag(CR_Mag), .Frm_Nsym(Frm_Nsym),
    .Fine_En(Fine_En), .Out_En(Out_En), .Frm_Start(Frm_Start),
    .Sym_Cnt(Sym_Cnt), .Peak_Idx(Peak_Idx), .Synch_Fail(Synch_Fail),
    .State(State)
`ifdef SYNCH_CTRL_STAT_EN
    , .Det_Cnt(Det_Cnt), .Fail_Cnt(Fail_Cnt), .Frm_Cnt(Frm_Cnt)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  task automatic tick();
    @(posedge CLK_I);
    @(negedge CLK_I);
  endtask

  task automatic do_reset();
    RST_I = 1'b1; CYC_I = 1'b0; Smp_Val = 1'b0; CM_Val = 1'b0; CR_Val = 1'b0;
    P_Mag = '0; R_Metric = '0; CR_Mag = '0; Frm_Nsym = '0;
    tick(); tick();
    RST_I = 1'b0; CYC_I = 1'b1;
    tick();
  endtask

  task automatic hits(input int n, input logic [22:0] p);
    for (int i = 0; i < n; i++) begin
      CM_Val = 1'b1; R_Metric = 22'd1000; P_Mag = p;
      tick();
    end
    CM_Val = 1'b0;
  endtask

  task automatic window(input int first, input int n, input int ia, input int ib,
                        input logic [7:0] pk, input logic [7:0] base);
    for (int i = first; i < first + n; i++) begin
      CR_Val = 1'b1;
      CR_Mag = ((i == ia) || (i == ib)) ? pk : base;
      tick();
    end
    CR_Val = 1'b0;
  endtask

  task automatic smp(input int n);
    for (int i = 0; i < n; i++) begin
      Smp_Val = 1'b1;
      tick();
    end
    Smp_Val = 1'b0;
  endtask

  task automatic test_reset();
    RST_I = 1'b1; CYC_I = 1'b1; Smp_Val = 1'b1; CM_Val = 1'b1; CR_Val = 1'b1;
    P_Mag = 23'd800; R_Metric = 22'd1000; CR_Mag = 8'd90; Frm_Nsym = 10'd3;
    tick(); tick();
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", State); end
    checks++; if (Fine_En !== 1'b0 || Out_En !== 1'b0 || Synch_Fail !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got fine=%b out=%b fail=%b expected 000", Fine_En, Out_En, Synch_Fail); end
    checks++; if (Sym_Cnt !== 10'd0 || Peak_Idx !== 8'd0) begin
      errors++; $display("FAIL reset_counts: got sym=%0d peak=%0d expected 0 0", Sym_Cnt, Peak_Idx); end
`ifdef SYNCH_CTRL_STAT_EN
    checks++; if (Det_Cnt !== 16'd0 || Fail_Cnt !== 16'd0 || Frm_Cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stats: got %0d %0d %0d expected 0 0 0", Det_Cnt, Fail_Cnt, Frm_Cnt); end
`endif
    CM_Val = 1'b0; CR_Val = 1'b0; Smp_Val = 1'b0;
    RST_I = 1'b0;
    tick();
    checks++; if (State !== 3'd1) begin errors++; $display("FAIL idle_to_coarse: got %0d expected 1", State); end
  endtask

  task automatic test_detect();
    do_reset();
    hits(31, 23'd800);
    checks++; if (State !== 3'd1 || Fine_En !== 1'b0) begin
      errors++; $display("FAIL detect_31: got state=%0d fine=%b expected 1 0", State, Fine_En); end
    hits(1, 23'd800);
    checks++; if (State !== 3'd2 || Fine_En !== 1'b1) begin
      errors++; $display("FAIL detect_32: got state=%0d fine=%b expected 2 1", State, Fine_En); end
  endtask

  task automatic test_miss();
    do_reset();
    hits(31, 23'd800);
    CM_Val = 1'b1; R_Metric = 22'd50; P_Mag = 23'd100;
    tick();
    CM_Val = 1'b0;
    hits(31, 23'd800);
    checks++; if (State !== 3'd1) begin errors++; $display("FAIL miss_low_pwr: got state=%0d expected 1", State); end
    CM_Val = 1'b1; R_Metric = 22'd1000; P_Mag = 23'd700;
    tick();
    CM_Val = 1'b0;
    hits(10, 23'd800);
    tick(); tick();
    hits(21, 23'd800);
    checks++; if (State !== 3'd1 || Fine_En !== 1'b0) begin
      errors++; $display("FAIL miss_p_low: got state=%0d fine=%b expected 1 0", State, Fine_En); end
    hits(1, 23'd750);
    checks++; if (State !== 3'd2 || Fine_En !== 1'b1) begin
      errors++; $display("FAIL detect_after_miss: got state=%0d fine=%b expected 2 1", State, Fine_En); end
  endtask

  task automatic test_frame();
    do_reset();
    hits(32, 23'd800);
    window(0, 143, 20, 84, 8'd90, 8'd10);
    checks++; if (Fine_En !== 1'b1) begin errors++; $display("FAIL fine_en_143: got %b expected 1", Fine_En); end
    window(143, 1, 20, 84, 8'd90, 8'd10);
    checks++; if (Fine_En !== 1'b0 || State !== 3'd2) begin
      errors++; $display("FAIL window_end: got fine=%b state=%0d expected 0 2", Fine_En, State); end
    Frm_Nsym = 10'd3;
    tick();
    checks++; if (State !== 3'd3 || Peak_Idx !== 8'd20 || Synch_Fail !== 1'b0) begin
      errors++; $display("FAIL decision: got state=%0d peak=%0d fail=%b expected 3 20 0", State, Peak_Idx, Synch_Fail); end
    smp(30);
    tick();
    smp(37);
    checks++; if (State !== 3'd3 || Out_En !== 1'b0) begin
      errors++; $display("FAIL align_67: got state=%0d out=%b expected 3 0", State, Out_En); end
    smp(1);
    checks++; if (State !== 3'd4 || Out_En !== 1'b1 || Sym_Cnt !== 10'd0) begin
      errors++; $display("FAIL data_entry: got state=%0d out=%b sym=%0d expected 4 1 0", State, Out_En, Sym_Cnt); end
    for (int k = 1; k <= 240; k++) begin
      if (k == 100) begin
        Smp_Val = 1'b0;
        tick();
      end
      Smp_Val = 1'b1;
      #1;
      checks++; if (Frm_Start !== (k == 1)) begin
        errors++; $display("FAIL frm_start k=%0d: got %b expected %b", k, Frm_Start, (k == 1)); end
      checks++; if (Out_En !== 1'b1) begin errors++; $display("FAIL gate k=%0d: got %b expected 1", k, Out_En); end
      tick();
      if (k == 1) Frm_Nsym = 10'd7;
      if (k == 80 || k == 160) begin
        checks++; if (Sym_Cnt !== 10'(k / 80)) begin
          errors++; $display("FAIL sym_cnt k=%0d: got %0d expected %0d", k, Sym_Cnt, k / 80); end
      end
    end
    Smp_Val = 1'b0;
    checks++; if (Out_En !== 1'b0 || State !== 3'd0 || Sym_Cnt !== 10'd3) begin
      errors++; $display("FAIL frame_end: got out=%b state=%0d sym=%0d expected 0 0 3", Out_En, State, Sym_Cnt); end
    tick();
    checks++; if (State !== 3'd1 || Sym_Cnt !== 10'd3) begin
      errors++; $display("FAIL after_frame: got state=%0d sym=%0d expected 1 3", State, Sym_Cnt); end
`ifdef SYNCH_CTRL_STAT_EN
    checks++; if (Frm_Cnt !== 16'd1 || Det_Cnt !== 16'd1) begin
      errors++; $display("FAIL frame_stats: got frm=%0d det=%0d expected 1 1", Frm_Cnt, Det_Cnt); end
`endif
  endtask

  task automatic test_fail();
    do_reset();
    hits(32, 23'd800);
    window(0, 144, 5, -1, 8'd30, 8'd10);
    tick();
    checks++; if (Synch_Fail !== 1'b1 || State !== 3'd1 || Out_En !== 1'b0) begin
      errors++; $display("FAIL low_peak: got fail=%b state=%0d out=%b expected 1 1 0", Synch_Fail, State, Out_En); end
    checks++; if (Peak_Idx !== 8'd5) begin errors++; $display("FAIL low_peak_idx: got %0d expected 5", Peak_Idx); end
    tick();
    checks++; if (Synch_Fail !== 1'b0 || Out_En !== 1'b0) begin
      errors++; $display("FAIL fail_pulse_len: got fail=%b out=%b expected 0 0", Synch_Fail, Out_En); end
`ifdef SYNCH_CTRL_STAT_EN
    checks++; if (Fail_Cnt !== 16'd1 || Det_Cnt !== 16'd1) begin
      errors++; $display("FAIL fail_stats: got fail=%0d det=%0d expected 1 1", Fail_Cnt, Det_Cnt); end
`endif
  endtask

  task automatic test_abort_align();
    do_reset();
    hits(32, 23'd800);
    window(0, 144, 20, -1, 8'd90, 8'd10);
    tick();
    smp(10);
    CYC_I = 1'b0; Smp_Val = 1'b1;
    tick();
    checks++; if (State !== 3'd0 || Synch_Fail !== 1'b1 || Out_En !== 1'b0) begin
      errors++; $display("FAIL abort_align: got state=%0d fail=%b out=%b expected 0 1 0", State, Synch_Fail, Out_En); end
`ifdef SYNCH_CTRL_STAT_EN
    checks++; if (Fail_Cnt !== 16'd1 || Det_Cnt !== 16'd1) begin
      errors++; $display("FAIL abort_stats: got fail=%0d det=%0d expected 1 1", Fail_Cnt, Det_Cnt); end
`endif
    CYC_I = 1'b1; Smp_Val = 1'b0;
    tick();
    checks++; if (State !== 3'd1 || Synch_Fail !== 1'b0) begin
      errors++; $display("FAIL abort_recover: got state=%0d fail=%b expected 1 0", State, Synch_Fail); end
  endtask

  task automatic test_data_abort();
    do_reset();
    hits(32, 23'd800);
    window(0, 144, 0, -1, 8'd90, 8'd10);
    Frm_Nsym = 10'd0;
    tick();
    smp(48);
    checks++; if (State !== 3'd4) begin errors++; $display("FAIL w48_entry: got state=%0d expected 4", State); end
    smp(100);
    checks++; if (Sym_Cnt !== 10'd1 || Out_En !== 1'b1) begin
      errors++; $display("FAIL unlimited: got sym=%0d out=%b expected 1 1", Sym_Cnt, Out_En); end
    CYC_I = 1'b0;
    tick();
    checks++; if (State !== 3'd0 || Synch_Fail !== 1'b0 || Out_En !== 1'b0 || Sym_Cnt !== 10'd1) begin
      errors++; $display("FAIL data_end: got state=%0d fail=%b out=%b sym=%0d expected 0 0 0 1",
                         State, Synch_Fail, Out_En, Sym_Cnt); end
`ifdef SYNCH_CTRL_STAT_EN
    checks++; if (Frm_Cnt !== 16'd1 || Fail_Cnt !== 16'd0) begin
      errors++; $display("FAIL data_stats: got frm=%0d fail=%0d expected 1 0", Frm_Cnt, Fail_Cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_detect();
    test_miss();
    test_frame();
    test_fail();
    test_abort_align();
    test_data_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
